// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared width helpers and window bit-offset function for the ring line buffer.
// rev 1.0
`default_nettype none

package line_buffer_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Defaults for the reference configuration; modules re-derive from their own parameters.
  localparam int K_DEF  = 3;
  localparam int W_DEF  = 512;
  localparam int COL_W  = clog2(W_DEF);
  localparam int BANK_W = clog2(K_DEF + 1);
  localparam int CNT_W  = clog2(K_DEF + 2);

  // Bit offset of window row i (0 = oldest), column j inside a k-row by n-column window.
  function automatic int win_off(input int i, input int j, input int k, input int n, input int dw);
    return ((k - 1 - i) * n + (n - 1 - j)) * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lb_row_bank.sv
// lb_row_bank: one W-pixel row store, single write port, n-wide combinational read (LINE_BUFFER_RING_PAD_EN adds zero fill).
// rev 1.0
`default_nettype none

module lb_row_bank
  import line_buffer_pkg::*;
#(
  parameter int W        = 512,
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int COL_BITS = clog2(W)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [COL_BITS-1:0] wr_col,
  input  logic [DW-1:0]       wr_data,
  input  logic [COL_BITS-1:0] rd_col,
  output logic [N*DW-1:0]     rd_data
);

  logic [DW-1:0] mem [W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_col] <= wr_data;
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [DW-1:0] px;
`ifdef LINE_BUFFER_RING_PAD_EN
    // Window is centred on rd_col; columns falling off either edge read as zero.
    localparam int SHIFT = (N - 1) / 2;
    int pos;
    always_comb begin
      pos = int'(rd_col) + j - SHIFT;
      if (pos < 0 || pos >= W) px = '0;
      else                     px = mem[pos[COL_BITS-1:0]];
    end
`else
    logic [COL_BITS-1:0] idx;
    assign idx = rd_col + COL_BITS'(j);
    assign px  = mem[idx];
`endif
    assign rd_data[win_off(0, j, 1, N, DW) +: DW] = px;
  end

endmodule

`default_nettype wire

// File: rtl/line_buffer_ring.sv
// line_buffer_ring: K+1 rotating row banks emitting a K x n pixel window with horizontal stride.
// Optional horizontal zero padding under LINE_BUFFER_RING_PAD_EN. rev 1.0
`default_nettype none

module line_buffer_ring
  import line_buffer_pkg::*;
#(
  parameter int K      = 3,
  parameter int W      = 512,
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int STRIDE = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DW-1:0]           i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  input  logic                    i_rd_data,
  output logic [K*N*DW-1:0]       o_data,
  output logic                    o_data_valid,
  output logic                    o_row_done,
  output logic [clog2(K+2)-1:0]   o_rows_avail
);

  localparam int COL_BITS  = clog2(W);
  localparam int BANK_BITS = clog2(K + 1);
  localparam int CNT_BITS  = clog2(K + 2);
  localparam int NB        = K + 1;
  localparam int SLICE     = N * DW;

  logic [COL_BITS-1:0]  wr_col, rd_col;
  logic [BANK_BITS-1:0] wr_bank, rd_bank;
  logic [CNT_BITS-1:0]  rows_avail;
  logic [SLICE-1:0]     bank_rd [NB];
  logic [K*N*DW-1:0]    window;
  logic                 wr_fire, wr_row_end, rd_fire, rd_row_end, rd_last_col;

  assign o_data_ready = (rows_avail < CNT_BITS'(K + 1));
  assign o_rows_avail = rows_avail;
  assign wr_fire      = i_data_valid && o_data_ready;
  assign wr_row_end   = wr_fire && (wr_col == COL_BITS'(W - 1));
  assign rd_fire      = i_rd_data && (rows_avail >= CNT_BITS'(K));
  assign rd_row_end   = rd_fire && rd_last_col;

`ifdef LINE_BUFFER_RING_PAD_EN
  assign rd_last_col = (int'(rd_col) + STRIDE >= W);
`else
  assign rd_last_col = (int'(rd_col) + STRIDE + N > W);
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    lb_row_bank #(
      .W  (W),
      .N  (N),
      .DW (DW)
    ) u_bank (
      .clk     (i_clk),
      .wr_en   (wr_fire && (wr_bank == BANK_BITS'(b))),
      .wr_col  (wr_col),
      .wr_data (i_data),
      .rd_col  (rd_col),
      .rd_data (bank_rd[b])
    );
  end

  // Window row i comes from the i-th oldest bank, wrapping modulo K+1.
  for (genvar i = 0; i < K; i++) begin : g_win
    logic [BANK_BITS:0] sum, sel;
    assign sum = {1'b0, rd_bank} + (BANK_BITS + 1)'(i);
    assign sel = (sum >= (BANK_BITS + 1)'(NB)) ? sum - (BANK_BITS + 1)'(NB) : sum;
    assign window[win_off(i, N - 1, K, N, DW) +: SLICE] = bank_rd[sel[BANK_BITS-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_col       <= '0;
      rd_col       <= '0;
      wr_bank      <= '0;
      rd_bank      <= '0;
      rows_avail   <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_row_done   <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_row_end) begin
          wr_col  <= '0;
          wr_bank <= (wr_bank == BANK_BITS'(K)) ? '0 : wr_bank + BANK_BITS'(1);
        end else begin
          wr_col  <= wr_col + COL_BITS'(1);
        end
      end
      if (rd_fire) begin
        o_data <= window;
        if (rd_row_end) begin
          rd_col  <= '0;
          rd_bank <= (rd_bank == BANK_BITS'(K)) ? '0 : rd_bank + BANK_BITS'(1);
        end else begin
          rd_col  <= COL_BITS'(int'(rd_col) + STRIDE);
        end
      end
      o_data_valid <= rd_fire;
      o_row_done   <= rd_row_end;
      case ({wr_row_end, rd_row_end})
        2'b10:   rows_avail <= rows_avail + CNT_BITS'(1);
        2'b01:   rows_avail <= rows_avail - CNT_BITS'(1);
        default: rows_avail <= rows_avail;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/line_buffer_ring.md
Name: line_buffer_ring

Overview:
Parametrised successor to the flat M*W line buffer. Stores K+1 rotating row banks of W pixels, each DW bits wide. Emits a K-row by n-column window with a programmable horizontal stride. Supports concurrent write and read through row rotation, and applies write backpressure. Sits between the pixel input stream and the convolution/PE array.

Parameters:
K, 3, rows in the output window (vertical kernel size)
W, 512, pixels per row
n, 4, columns in the output window (horizontal kernel size); must satisfy n <= W
DW, 8, bits per pixel
STRIDE, 1, horizontal column step between consecutive windows; must be >= 1

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  reset; asynchronous, active-low
i_data  in  DW  input pixel
i_data_valid  in  1  i_data is valid this cycle
o_data_ready  out  1  block can accept a pixel this cycle
i_rd_data  in  1  request the next window
o_data  out  K*n*DW  window output
o_data_valid  out  1  o_data was updated this cycle (single-cycle pulse)
o_row_done  out  1  pulse: last window of the oldest row was emitted
o_rows_avail  out  clog2(K+2)  number of complete rows stored (0..K+1)

Behaviour:
- Reset (async assert, sync release):
  - wr_col, rd_col, wr_bank, rd_bank, rows_avail all reset to 0.
  - o_data resets to 0; o_data_valid and o_row_done reset to 0; o_data_ready resets to 1.
  - Bank contents are not reset.
- Write side:
  - A write occurs when i_data_valid && o_data_ready. It stores i_data at bank[wr_bank][wr_col], then increments wr_col.
  - When wr_col == W-1: wr_col returns to 0, wr_bank advances by 1 mod (K+1), and rows_avail increments.
  - o_data_ready = (rows_avail < K+1). This is combinational from registered state.
  - A pixel presented while o_data_ready is low is dropped, with no state change.
- Read side:
  - A read is accepted when i_rd_data && rows_avail >= K; otherwise the request is ignored and o_data holds its value.
  - On an accepted read, o_data is registered on the next edge (1-cycle latency) and o_data_valid pulses for that cycle.
  - Byte placement: window row i (i=0 is the oldest, at bank (rd_bank+i) mod (K+1)) and column j take pixel bank[..][rd_col+j], placed at bit offset ((K-1-i)*n + (n-1-j))*DW. The oldest row's first pixel therefore lands in the MSBs.
  - After each accepted read, rd_col += STRIDE.
  - Last window of a row: the read for which rd_col+STRIDE+n > W. On that read, rd_col returns to 0, rd_bank advances mod (K+1), rows_avail decrements, and o_row_done pulses alongside o_data_valid.
  - Windows per row: (W-n)/STRIDE+1, using integer division.
- Simultaneous write-row-complete and read-row-release in the same cycle: rows_avail is unchanged.
- Reading and writing never touch the same bank: the writer uses a bank only if rows_avail < K+1, and the reader uses only the K oldest complete banks.
- Pointer widths: use clog2(W) and clog2(K+1) bits. Counters wrap explicitly at W and K+1, never at a power of 2.

Optional Feature:
LINE_BUFFER_RING_PAD_EN
- Defined: horizontal zero padding is enabled.
  - Window column j maps to pixel rd_col + j - (n-1)/2.
  - Out-of-range columns read as 0.
  - rd_col runs from 0 to W-1 in steps of STRIDE, giving ceil(W/STRIDE) windows per row.
  - The last window of a row is the read where rd_col+STRIDE >= W.
- Undefined: no padding, using the window count and last-window rule above. No pad logic is synthesised.

Decomposition:
- Package line_buffer_pkg contains:
  - clog2 function;
  - derived widths COL_W = clog2(W), BANK_W = clog2(K+1), CNT_W = clog2(K+2);
  - a window-offset helper function.
- One natural sub-module, lb_row_bank, instantiated K+1 times. It has a DW-wide single write port and an n-wide combinational read starting at a given column, with zero-fill when the pad macro is defined.
- The top level holds the counters, bank rotation and output register.

Test Plan:
Use K=3, W=8, n=4, DW=8, STRIDE=1 unless a line says otherwise.
1. Reset, then write bytes 0x00..0x17 (24 pixels) -> o_rows_avail=3. Read once -> one cycle later o_data=0x00010203_08090A0B_10111213 with o_data_valid=1.
2. Issue 5 consecutive reads -> last read gives 0x04050607_0C0D0E0F_14151617 with o_row_done=1 and o_rows_avail=2. A 6th read is ignored (o_data_valid=0).
3. Write 32 pixels with no reads -> o_data_ready falls after the 32nd pixel. A 33rd pixel with value 0xAA is dropped and o_rows_avail stays 4.
4. Write the last pixel of row 3 in the same cycle as the last read of row 0 -> o_rows_avail stays 3 and both wr_bank and rd_bank advance.
5. Stream 6 rows with reads interleaved -> bank indices wrap mod 4. The first window of rows 3..5 equals 0x18191A1B_20212223_28292A2B.
6. Assert i_rst_n low mid-read -> o_data_valid, o_row_done and o_rows_avail go to 0 immediately, o_data goes to 0, and o_data_ready goes to 1. With STRIDE=2 and no pad, each row yields 3 windows.
